dds_lut_loader_ctrl: RTL and testbench
======================================

Name: dds_lut_loader_ctrl

Overview:
- Sequencer in front of the DDS core: streams sine-LUT samples from a valid/ready source into the DDS LUT write port (we/addr_wr/data_wr).
- After the full table is written, issues the initial set_phase pulse, then sits in RUN, forwarding runtime phase-change requests as single-cycle set_phase pulses.
- Replaces bench-driven LUT loading; sits between the host/UART byte path and the DDS core.

Parameters:
- DATA_LEN, 8, LUT sample width (matches config DATA_LEN)
- ROWS_BASE_2, 9, LUT address width (matches config ROWS_BASE_2)
- DEPTH, 360, number of LUT entries written per load; DEPTH <= 2**ROWS_BASE_2
- PHASE_W, 9, DDS phase width

Ports:
- src_clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin (re)load sequence; level sampled each cycle
- init_phase  in  PHASE_W  phase applied at end of load, sampled when start is accepted
- s_valid  in  1  sample stream valid
- s_data  in  DATA_LEN  sample value
- s_ready  out  1  controller accepts a sample this cycle
- phase_req  in  1  runtime phase-change request (single-cycle)
- phase_val  in  PHASE_W  requested phase
- dds_we  out  1  LUT write enable to DDS
- dds_addr_wr  out  ROWS_BASE_2  LUT write address
- dds_data_wr  out  DATA_LEN  LUT write data
- dds_set_phase  out  1  one-cycle phase-load strobe to DDS
- dds_phase  out  PHASE_W  phase value presented with dds_set_phase
- loading  out  1  high in LOAD
- loaded  out  1  table complete, DDS running
- phase_err  out  1  one-cycle pulse: rejected phase (>= DEPTH)

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; sample counter 0; stored init_phase 0.
- States: IDLE, LOAD, SETPH, RUN.
- IDLE: start=1 -> LOAD next cycle; init_phase captured. If init_phase >= DEPTH, capture 0 and pulse phase_err.
- LOAD: s_ready=1 combinationally equal to (state==LOAD). Handshake = s_valid & s_ready. Each handshake registers a write: next cycle dds_we=1, dds_addr_wr=count, dds_data_wr=s_data. Otherwise dds_we=0, with addr/data holding last values. Count increments per handshake. The handshake with count==DEPTH-1 -> SETPH; s_ready drops the same edge, so no sample is accepted past DEPTH. Gaps in s_valid stall without writes. start during LOAD is ignored.
- SETPH (1 cycle): at exit, dds_set_phase=1 and dds_phase=stored init_phase for exactly one cycle. That pulse coincides with the first RUN cycle and follows the final dds_we cycle. -> RUN.
- RUN: loaded=1.
  - phase_req with phase_val < DEPTH -> next cycle dds_set_phase=1, dds_phase=phase_val.
  - phase_req with phase_val >= DEPTH -> no strobe; phase_err=1 next cycle; dds_phase unchanged.
  - Back-to-back requests each produce their own pulse, one cycle later.
- start in RUN -> reload: loaded=0 next cycle; state LOAD; count cleared; new init_phase captured. start and phase_req in the same cycle: start wins, phase_req dropped, no strobe.
- Latency: sample handshake -> dds_we 1 cycle; phase_req -> dds_set_phase 1 cycle; last sample handshake -> dds_set_phase 2 cycles.
- Counter width ROWS_BASE_2; never wraps, since LOAD exits at DEPTH-1.
- rst_n asserted mid-LOAD: write in flight is dropped (dds_we=0 immediately); table treated as invalid; full reload required.

Decomposition:
- Shared package/include: state encoding (IDLE/LOAD/SETPH/RUN localparams), DEPTH, PHASE_W, reusing config DATA_LEN/ROWS_BASE_2.
- Optional sub-module dds_phase_gate: range check + one-cycle strobe register for phase_req. Everything else inline.

Test Plan:
- Reset then start with init_phase=90; stream 360 samples with s_valid held high -> 360 dds_we pulses at addr 0..359 with matching data; s_ready low after 360th; dds_set_phase=1, dds_phase=90 two cycles after last handshake; loaded=1.
- Same load with s_valid toggling 1/0 -> writes only on valid cycles; addresses contiguous; completion after exactly 360 accepted samples.
- In RUN, phase_req phase_val=180 then phase_val=400 on consecutive cycles -> set_phase pulse with 180; phase_err pulse next; dds_phase stays 180.
- In RUN, start=1 and phase_req=1 (phase_val=45) same cycle -> no set_phase; loaded=0; LOAD restarts at addr 0.
- rst_n low after 100 samples -> outputs 0 asynchronously; after release and start, writes restart at addr 0.
- start with init_phase=360 -> phase_err pulse; final dds_phase=0 after load.

Source files
------------

// File: rtl/dds_lut_loader_ctrl_pkg.sv
// Shared definitions for the DDS LUT loader: default geometry, sequencer states
// and the phase range check used by both the loader and the runtime phase gate.
package dds_lut_loader_ctrl_pkg;

    localparam int unsigned CFG_DATA_LEN    = 8;
    localparam int unsigned CFG_ROWS_BASE_2 = 9;
    localparam int unsigned CFG_DEPTH       = 360;
    localparam int unsigned CFG_PHASE_W     = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SETPH = 2'd2,
        ST_RUN   = 2'd3
    } ldr_state_t;

    // A phase is only meaningful if it addresses a written LUT entry.
    function automatic logic phase_in_range(input logic [31:0] phase, input int unsigned depth);
        return phase < depth;
    endfunction

endpackage

// File: rtl/dds_lut_loader_ctrl_phase_gate.sv
// Registers one-cycle phase-load strobes towards the DDS: either the forced
// post-load phase or a range-checked runtime request.
module dds_phase_gate
    import dds_lut_loader_ctrl_pkg::*;
#(
    parameter int unsigned PHASE_W = CFG_PHASE_W,
    parameter int unsigned DEPTH   = CFG_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_en,
    input  logic               req,
    input  logic [PHASE_W-1:0] val,
    input  logic               force_load,
    input  logic [PHASE_W-1:0] force_val,
    output logic               set_phase,
    output logic [PHASE_W-1:0] phase,
    output logic               err
);

    logic req_live;
    logic in_range;

    always_comb begin
        req_live = req_en & req;
        in_range = phase_in_range(32'(val), DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_phase <= 1'b0;
            phase     <= '0;
            err       <= 1'b0;
        end else begin
            set_phase <= force_load | (req_live & in_range);
            err       <= req_live & ~in_range;
            if (force_load) begin
                phase <= force_val;
            end else if (req_live & in_range) begin
                phase <= val;
            end
        end
    end

endmodule

// File: rtl/dds_lut_loader_ctrl.sv
// Streams sine-LUT samples into the DDS write port, then issues the initial
// phase load and forwards runtime phase-change requests while running.
module dds_lut_loader_ctrl
    import dds_lut_loader_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LEN    = CFG_DATA_LEN,
    parameter int unsigned ROWS_BASE_2 = CFG_ROWS_BASE_2,
    parameter int unsigned DEPTH       = CFG_DEPTH,
    parameter int unsigned PHASE_W     = CFG_PHASE_W
) (
    input  logic                   src_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PHASE_W-1:0]     init_phase,
    input  logic                   s_valid,
    input  logic [DATA_LEN-1:0]    s_data,
    output logic                   s_ready,
    input  logic                   phase_req,
    input  logic [PHASE_W-1:0]     phase_val,
    output logic                   dds_we,
    output logic [ROWS_BASE_2-1:0] dds_addr_wr,
    output logic [DATA_LEN-1:0]    dds_data_wr,
    output logic                   dds_set_phase,
    output logic [PHASE_W-1:0]     dds_phase,
    output logic                   loading,
    output logic                   loaded,
    output logic                   phase_err
);

    localparam logic [ROWS_BASE_2-1:0] LAST_ADDR = ROWS_BASE_2'(DEPTH - 1);

    ldr_state_t             state;
    ldr_state_t             state_nxt;
    logic [ROWS_BASE_2-1:0] count;
    logic [PHASE_W-1:0]     init_q;
    logic                   init_err;
    logic                   gate_err;
    logic                   hs;
    logic                   hs_last;
    logic                   start_acc;
    logic                   init_ok;
    logic                   req_en;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        hs        = 1'b0;
        hs_last   = 1'b0;
        start_acc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                hs      = s_valid;
                hs_last = s_valid && (count == LAST_ADDR);
                if (hs_last) begin
                    state_nxt = ST_SETPH;
                end
            end
            ST_SETPH: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        init_ok   = phase_in_range(32'(init_phase), DEPTH);
        // start outranks a same-cycle phase request in RUN
        req_en    = (state == ST_RUN) & ~start;
        loading   = (state == ST_LOAD);
        loaded    = (state == ST_RUN);
        phase_err = init_err | gate_err;
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            init_q      <= '0;
            init_err    <= 1'b0;
            dds_we      <= 1'b0;
            dds_addr_wr <= '0;
            dds_data_wr <= '0;
        end else begin
            dds_we   <= hs;
            init_err <= start_acc & ~init_ok;
            if (start_acc) begin
                count  <= '0;
                init_q <= init_ok ? init_phase : '0;
            end else if (hs && !hs_last) begin
                count <= count + 1'b1;
            end
            if (hs) begin
                dds_addr_wr <= count;
                dds_data_wr <= s_data;
            end
        end
    end

    dds_phase_gate #(
        .PHASE_W (PHASE_W),
        .DEPTH   (DEPTH)
    ) u_phase_gate (
        .clk        (src_clk),
        .rst_n      (rst_n),
        .req_en     (req_en),
        .req        (phase_req),
        .val        (phase_val),
        .force_load (state == ST_SETPH),
        .force_val  (init_q),
        .set_phase  (dds_set_phase),
        .phase      (dds_phase),
        .err        (gate_err)
    );

endmodule

// File: tb/tb_dds_lut_loader_ctrl.sv
// Self-checking bench for dds_lut_loader_ctrl: randomized LUT loads and phase
// requests checked against an event-level reference model.
module tb_dds_lut_loader_ctrl;

    localparam int DEPTH = 360;
    localparam int DL    = 8;
    localparam int AW    = 9;
    localparam int PW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] init_phase = '0;
    logic          s_valid = 1'b0;
    logic [DL-1:0] s_data = '0;
    logic          s_ready;
    logic          phase_req = 1'b0;
    logic [PW-1:0] phase_val = '0;
    logic          dds_we;
    logic [AW-1:0] dds_addr_wr;
    logic [DL-1:0] dds_data_wr;
    logic          dds_set_phase;
    logic [PW-1:0] dds_phase;
    logic          loading;
    logic          loaded;
    logic          phase_err;

    always #5 clk = ~clk;

    dds_lut_loader_ctrl #(
        .DATA_LEN    (DL),
        .ROWS_BASE_2 (AW),
        .DEPTH       (DEPTH),
        .PHASE_W     (PW)
    ) dut (
        .src_clk       (clk),
        .rst_n         (rst_n),
        .start         (start),
        .init_phase    (init_phase),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .phase_req     (phase_req),
        .phase_val     (phase_val),
        .dds_we        (dds_we),
        .dds_addr_wr   (dds_addr_wr),
        .dds_data_wr   (dds_data_wr),
        .dds_set_phase (dds_set_phase),
        .dds_phase     (dds_phase),
        .loading       (loading),
        .loaded        (loaded),
        .phase_err     (phase_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed DDS-side events, tagged with the cycle they were seen in
    int wq_cyc[$];
    int wq_addr[$];
    int wq_data[$];
    int sp_cyc[$];
    int sp_val[$];
    int pe_cyc[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (dds_we === 1'b1) begin
                wq_cyc.push_back(cyc);
                wq_addr.push_back(int'(dds_addr_wr));
                wq_data.push_back(int'(dds_data_wr));
            end
            if (dds_set_phase === 1'b1) begin
                sp_cyc.push_back(cyc);
                sp_val.push_back(int'(dds_phase));
            end
            if (phase_err === 1'b1) pe_cyc.push_back(cyc);
        end
    end

    int lut[DEPTH];
    int hs_cyc[DEPTH];
    int start_cyc;
    int exp_phase = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_cyc.delete();
        wq_addr.delete();
        wq_data.delete();
        sp_cyc.delete();
        sp_val.delete();
        pe_cyc.delete();
    endtask

    task automatic test_reset();
        start = 1'b0; s_valid = 1'b0; phase_req = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({s_ready, dds_we, dds_addr_wr, dds_data_wr} !== '0) begin
            n_fail++;
            $display("FAIL reset_write_port: got %b expected 0", {s_ready, dds_we, dds_addr_wr, dds_data_wr});
        end
        n_checks++;
        if ({dds_set_phase, dds_phase, loading, loaded, phase_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 0", {dds_set_phase, dds_phase, loading, loaded, phase_err});
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (loading !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_start: got loading=%b s_ready=%b expected 0 0", loading, s_ready);
        end
    endtask

    task automatic do_start(input int p, input bit with_req, input int v);
        clear_mon();
        start = 1'b1;
        init_phase = PW'(p);
        if (with_req) begin
            phase_req = 1'b1;
            phase_val = PW'(v);
        end
        start_cyc = cyc;
        tick();
        start = 1'b0;
        phase_req = 1'b0;
        n_checks++;
        if (loading !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL enter_load: got loading=%b s_ready=%b expected 1 1", loading, s_ready);
        end
        if (with_req) begin
            n_checks++;
            if (dds_set_phase !== 1'b0 || loaded !== 1'b0) begin
                n_fail++;
                $display("FAIL start_beats_req: got set_phase=%b loaded=%b expected 0 0", dds_set_phase, loaded);
            end
        end
    endtask

    task automatic stream(input int n_lim, input bit toggle);
        int n = 0;
        int guard = 0;
        int rdy_bad = 0;
        bit ph = 1'b1;
        while (n < n_lim && guard < 4 * DEPTH + 10) begin
            s_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            s_data = DL'(lut[n]);
            if (s_valid) begin
                if (s_ready !== 1'b1) rdy_bad++;
                else begin
                    hs_cyc[n] = cyc;
                    n++;
                end
            end
            tick();
            guard++;
        end
        n_checks++;
        if (rdy_bad != 0 || n != n_lim) begin
            n_fail++;
            $display("FAIL stream_accept: got %0d accepted (%0d refused) expected %0d", n, rdy_bad, n_lim);
        end
    endtask

    task automatic finish_load(input int p);
        int last;
        int mism = 0;
        int exp_err;
        last = hs_cyc[DEPTH-1];
        exp_phase = (p < DEPTH) ? p : 0;
        exp_err = (p >= DEPTH) ? 1 : 0;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_last: got %b expected 0", s_ready);
        end
        s_valid = 1'b1;
        s_data = 8'hA5;
        repeat (3) tick();
        s_valid = 1'b0;
        n_checks++;
        if (wq_cyc.size() != DEPTH) begin
            n_fail++;
            $display("FAIL write_count: got %0d expected %0d", wq_cyc.size(), DEPTH);
        end
        for (int i = 0; i < wq_cyc.size() && i < DEPTH; i++) begin
            if (wq_addr[i] != i || wq_data[i] != lut[i] || wq_cyc[i] != hs_cyc[i] + 1) begin
                if (mism == 0)
                    $display("FAIL write_%0d: got addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                             i, wq_addr[i], wq_data[i], wq_cyc[i], i, lut[i], hs_cyc[i] + 1);
                mism++;
            end
        end
        n_checks++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL write_contents: got %0d bad writes expected 0", mism);
        end
        n_checks++;
        if (sp_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL load_set_phase_count: got %0d expected 1", sp_cyc.size());
        end else begin
            n_checks++;
            if (sp_cyc[0] != last + 2 || sp_val[0] != exp_phase) begin
                n_fail++;
                $display("FAIL load_set_phase: got cyc=%0d phase=%0d expected cyc=%0d phase=%0d",
                         sp_cyc[0], sp_val[0], last + 2, exp_phase);
            end
        end
        n_checks++;
        if (loaded !== 1'b1 || loading !== 1'b0 || dds_phase !== PW'(exp_phase)) begin
            n_fail++;
            $display("FAIL run_status: got loaded=%b loading=%b phase=%0d expected 1 0 %0d",
                     loaded, loading, dds_phase, exp_phase);
        end
        n_checks++;
        if (pe_cyc.size() != exp_err) begin
            n_fail++;
            $display("FAIL init_phase_err_count: got %0d expected %0d", pe_cyc.size(), exp_err);
        end else if (exp_err == 1) begin
            n_checks++;
            if (pe_cyc[0] != start_cyc + 1) begin
                n_fail++;
                $display("FAIL init_phase_err_cycle: got %0d expected %0d", pe_cyc[0], start_cyc + 1);
            end
        end
    endtask

    task automatic do_load(input int p, input bit toggle, input bit with_req, input int v);
        for (int i = 0; i < DEPTH; i++) lut[i] = int'($urandom_range(0, 255));
        do_start(p, with_req, v);
        stream(DEPTH, toggle);
        finish_load(p);
    endtask

    task automatic test_load_streaming();
        do_load(90, 1'b0, 1'b0, 0);
    endtask

    task automatic test_phase_directed();
        clear_mon();
        phase_req = 1'b1;
        phase_val = 9'd180;
        tick();
        phase_val = 9'd400;
        n_checks++;
        if (dds_set_phase !== 1'b1 || dds_phase !== 9'd180 || phase_err !== 1'b0) begin
            n_fail++;
            $display("FAIL req_180: got sp=%b phase=%0d err=%b expected 1 180 0", dds_set_phase, dds_phase, phase_err);
        end
        tick();
        phase_req = 1'b0;
        n_checks++;
        if (dds_set_phase !== 1'b0 || dds_phase !== 9'd180 || phase_err !== 1'b1) begin
            n_fail++;
            $display("FAIL req_400: got sp=%b phase=%0d err=%b expected 0 180 1", dds_set_phase, dds_phase, phase_err);
        end
        tick();
        n_checks++;
        if (phase_err !== 1'b0 || dds_set_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: got sp=%b err=%b expected 0 0", dds_set_phase, phase_err);
        end
        exp_phase = 180;
    endtask

    task automatic test_back_to_back();
        int e_sp_cyc[$];
        int e_sp_val[$];
        int e_pe_cyc[$];
        int bad = 0;
        clear_mon();
        for (int k = 0; k < 80; k++) begin
            phase_req = ($urandom_range(0, 3) != 0);
            phase_val = PW'($urandom_range(0, 511));
            if (phase_req) begin
                if (int'(phase_val) < DEPTH) begin
                    e_sp_cyc.push_back(cyc + 1);
                    e_sp_val.push_back(int'(phase_val));
                    exp_phase = int'(phase_val);
                end else begin
                    e_pe_cyc.push_back(cyc + 1);
                end
            end
            tick();
        end
        phase_req = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (sp_cyc.size() != e_sp_cyc.size() || pe_cyc.size() != e_pe_cyc.size()) begin
            n_fail++;
            $display("FAIL b2b_counts: got sp=%0d err=%0d expected sp=%0d err=%0d",
                     sp_cyc.size(), pe_cyc.size(), e_sp_cyc.size(), e_pe_cyc.size());
        end else begin
            foreach (e_sp_cyc[i]) if (sp_cyc[i] != e_sp_cyc[i] || sp_val[i] != e_sp_val[i]) bad++;
            foreach (e_pe_cyc[i]) if (pe_cyc[i] != e_pe_cyc[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL b2b_events: got %0d wrong events expected 0", bad);
            end
        end
        n_checks++;
        if (dds_phase !== PW'(exp_phase) || loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_final: got phase=%0d loaded=%b expected %0d 1", dds_phase, loaded, exp_phase);
        end
    endtask

    task automatic test_start_over_req();
        do_load(10, 1'b1, 1'b1, 45);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < DEPTH; i++) lut[i] = int'($urandom_range(0, 255));
        do_start(77, 1'b0, 0);
        stream(100, 1'b0);
        s_valid = 1'b0;
        n_checks++;
        if (dds_we !== 1'b1 || dds_addr_wr !== 9'd99) begin
            n_fail++;
            $display("FAIL pre_reset_write: got we=%b addr=%0d expected 1 99", dds_we, dds_addr_wr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dds_we, dds_addr_wr, dds_data_wr, s_ready, loading, loaded, dds_set_phase, dds_phase, phase_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0",
                     {dds_we, dds_addr_wr, dds_data_wr, s_ready, loading, loaded, dds_set_phase, dds_phase, phase_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (loading !== 1'b0 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got loading=%b loaded=%b expected 0 0", loading, loaded);
        end
        do_load(200, 1'b0, 1'b0, 0);
    endtask

    task automatic test_bad_init_phase();
        do_load(360, 1'b1, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_load_streaming();
        test_phase_directed();
        test_back_to_back();
        test_start_over_req();
        test_reset_mid_load();
        test_bad_init_phase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
